// File: rtl/shift_add_mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package shift_add_mult_pkg;

  // Operand width; the adder is fixed at 8 bits, so this is the only legal width.
  localparam int MUL_WIDTH = 8;

  // One add/shift step per multiplier bit.
  localparam int MUL_STEPS = 8;

  // Step counter width, enough to count MUL_STEPS steps.
  localparam int CNT_W = 3;

  // Counter value on the final RUN step.
  localparam logic [CNT_W-1:0] LAST_STEP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mult_if.sv
// Request/result bundle between the ALU sequencer and the multiplier.
interface shift_add_mult_if;
  import shift_add_mult_pkg::*;

  logic                     start;
  logic [MUL_WIDTH-1:0]     a;
  logic [MUL_WIDTH-1:0]     b;
  logic [2*MUL_WIDTH-1:0]   p;
  logic                     busy;
  logic                     done;

  // Requester side: issues operands, observes product and status.
  modport master (
    output start, a, b,
    input  p, busy, done
  );

  // Multiplier side: consumes operands, produces product and status.
  modport slave (
    input  start, a, b,
    output p, busy, done
  );

endinterface

// File: rtl/shift_add_mult_adder.sv
// 8-bit ripple adder with carry in, carry out and signed-overflow flag.
module shift_add_mult_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] y,
  output logic       c,
  output logic       v
);

  logic [8:0] sum_s;

  // Nine-bit sum so the carry falls out as the top bit.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
    y     = sum_s[7:0];
    c     = sum_s[8];
    // Overflow when both operands share a sign that the result does not.
    v     = (a[7] == b[7]) && (sum_s[7] != a[7]);
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned 8x8 -> 16 shift-and-add multiplier reusing the 8-bit adder.
// The upper half of P accumulates partial sums while the lower half holds the
// not-yet-consumed multiplier bits; each step adds and shifts right by one.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic            clk,
  input  logic            rstn,
  shift_add_mult_if.slave bus
);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [CNT_W-1:0]       count_r;
  logic [WIDTH-1:0]       mcand_r;
  logic [2*WIDTH-1:0]     p_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   load_s;
  logic                   step_s;

  logic [WIDTH-1:0]       adder_b_s;
  logic [WIDTH-1:0]       adder_y_s;
  logic                   adder_c_s;
  logic                   adder_v_unused_s;

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    if (p_r[0]) begin
      adder_b_s = mcand_r;
    end else begin
      adder_b_s = {WIDTH{1'b0}};
    end
  end

  // Overflow flag is meaningless for an unsigned multiply and stays unconnected.
  shift_add_mult_adder u_adder (
    .a  (p_r[2*WIDTH-1:WIDTH]),
    .b  (adder_b_s),
    .ci (1'b0),
    .y  (adder_y_s),
    .c  (adder_c_s),
    .v  (adder_v_unused_s)
  );

  // Next-state decode plus load/step strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (count_r == LAST_STEP) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        // A START here chains straight into the next product.
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, status flags and datapath registers; reset discards any partial product.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= {CNT_W{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      if (load_s) begin
        mcand_r <= bus.a;
        p_r     <= {{WIDTH{1'b0}}, bus.b};
        count_r <= {CNT_W{1'b0}};
      end else if (step_s) begin
        // Carry becomes the new MSB so the 9-bit partial sum is never lost.
        p_r     <= {adder_c_s, adder_y_s, p_r[WIDTH-1:1]};
        count_r <= count_r + 3'd1;
      end else begin
        p_r     <= p_r;
        count_r <= count_r;
      end
    end
  end

  assign bus.p    = p_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
